// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined Hack-style ALU.
//   - CTRL_* : bit positions of {zx,nx,zy,ny,f,no} inside the 6-bit ctrl word
//   - ALU_*  : commonly used ctrl encodings
//   - state_e: sequencer state of alu_pipe (single-cycle op vs. iterative multiply)
package alu_pkg;

  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  localparam logic [5:0] ALU_ADD  = 6'b000010;
  localparam logic [5:0] ALU_SUB  = 6'b010011;
  localparam logic [5:0] ALU_ZERO = 6'b101010;
  localparam logic [5:0] ALU_NEG1 = 6'b111010;
  localparam logic [5:0] ALU_AND  = 6'b000000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational Hack ALU with carry and signed-overflow flags.
//   x, y  : WIDTH-bit operands
//   ctrl  : {zx,nx,zy,ny,f,no}
//   res   : result after the optional final inversion
//   carry : carry-out of xb+yb when f=1, else 0
//   ovf   : signed overflow of xb+yb when f=1, else 0
// Both flags describe the add itself, before the no inversion is applied.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] xa, xb, ya, yb, r;
  logic [WIDTH:0]   sum;

  always_comb begin
    xa  = ctrl[CTRL_ZX] ? '0 : x;
    xb  = ctrl[CTRL_NX] ? ~xa : xa;
    ya  = ctrl[CTRL_ZY] ? '0 : y;
    yb  = ctrl[CTRL_NY] ? ~ya : ya;
    sum = {1'b0, xb} + {1'b0, yb};
    r   = ctrl[CTRL_F] ? sum[WIDTH-1:0] : (xb & yb);
    res = ctrl[CTRL_NO] ? ~r : r;
    carry = ctrl[CTRL_F] & sum[WIDTH];
    // Overflow: both addends share a sign and the sum's sign differs from it.
    ovf = ctrl[CTRL_F] & (xb[WIDTH-1] == yb[WIDTH-1]) & (sum[WIDTH-1] != xb[WIDTH-1]);
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered Hack ALU with valid/ready handshakes, a one-entry
// output register, extended flags and an optional iterative multiplier.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : input beat handshake (x, y, ctrl, mul sampled on transfer)
//   x, y                : operands
//   ctrl                : {zx,nx,zy,ny,f,no}
//   mul                 : select shift-add multiply (honoured only when MUL_EN=1)
//   out_valid/out_ready : output handshake for the result register
//   out, zr, ng         : result, out==0, out[WIDTH-1]
//   carry, ovf          : adder carry-out / signed overflow (multiply: ovf = high half nonzero)
// Hack ops complete on the accepting edge; a multiply takes WIDTH further edges,
// during which no new beat is accepted.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             carry,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e state, state_next;

  logic [WIDTH-1:0]   core_res;
  logic               core_carry, core_ovf;

  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  logic               accept, mul_sel, mul_start, mul_done, load;
  logic [WIDTH-1:0]   load_res;
  logic               load_carry, load_ovf;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x     (x),
    .y     (y),
    .ctrl  (ctrl),
    .res   (core_res),
    .carry (core_carry),
    .ovf   (core_ovf)
  );

  // The slot may take a new beat when it is empty or being drained this edge.
  assign in_ready  = !reset && (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_sel   = (MUL_EN != 0) && mul;
  assign mul_start = accept && mul_sel;
  assign mul_done  = (state == MUL) && (cnt == '0);

  // Accumulator value after this edge's partial product; used both for the
  // register update and for the result on the final edge.
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: if (mul_start) state_next = MUL;
      MUL:  if (mul_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load       = (accept && !mul_sel) || mul_done;
    load_res   = core_res;
    load_carry = core_carry;
    load_ovf   = core_ovf;
    if (mul_done) begin
      load_res   = acc_next[WIDTH-1:0];
      load_carry = 1'b0;
      load_ovf   = |acc_next[2*WIDTH-1:WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_next;
      if (mul_start) begin
        cnt <= CNT_W'(WIDTH - 1);
      end else if ((state == MUL) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      // A load on a draining edge keeps the slot full.
      out_valid <= load || (out_valid && !out_ready);
      if (load) begin
        out   <= load_res;
        zr    <= (load_res == '0);
        ng    <= load_res[WIDTH-1];
        carry <= load_carry;
        ovf   <= load_ovf;
      end
    end
  end

  // NOTE: multiplier datapath registers are not reset; they are always
  // initialised on the accepting edge before they are read.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand  <= {{WIDTH{1'b0}}, x};
      mplier <= y;
      acc    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule
